jt12_wrqueue: RTL and testbench

//  Host-side write queue sitting directly upstream of the jt12 core bus (din/addr/cs_n/wr_n/dout).

---
 rtl/jt12_wrqueue_pkg.sv | 21 ++
 rtl/jt12_wrq_fifo.sv | 50 +++++
 rtl/jt12_wrqueue.sv | 167 ++++++++++++++++
 tb/tb_jt12_wrqueue.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jt12_wrqueue_pkg.sv
// Shared types for the jt12 host write queue: FSM states,
// queue entry layout and status busy bit position.
package jt12_wrqueue_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_RECOV,
    S_POLL,
    S_SAMPLE
  } wrq_state_e;

  localparam int ENTRY_W  = 10;
  localparam int BUSY_BIT = 7;

  typedef struct packed {
    logic [1:0] addr;
    logic [7:0] din;
  } wrq_entry_t;

endpackage

// File: rtl/jt12_wrq_fifo.sv
// DEPTH-entry register FIFO of {addr,din} write entries.
// Ports: push/pop strobes, wdata/rdata (head), full, empty, level.
module jt12_wrq_fifo
  import jt12_wrqueue_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  wrq_entry_t wdata,
  output wrq_entry_t rdata,
  output logic       full,
  output logic       empty,
  output logic [AW:0] level
);

  wrq_entry_t  mem [DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic        do_push;
  logic        do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Extra pointer MSB tells full from empty.
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty = (wptr == rptr);
  assign level = wptr - rptr;
  assign rdata = mem[rptr[AW-1:0]];

endmodule

// File: rtl/jt12_wrqueue.sv
// Host write queue in front of the jt12 bus; replays writes, polls busy.
// Option JT12_WRQ_DROPCNT_EN: saturating 8-bit dropped-write counter.
module jt12_wrqueue
  import jt12_wrqueue_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int AW       = 4,
  parameter int WR_PULSE = 2,
  parameter int BUSY_TMO = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        host_wr,
  input  logic [1:0]  host_addr,
  input  logic [7:0]  host_din,
  output logic        host_full,
  output logic        host_empty,
  output logic [AW:0] host_level,
  output logic [7:0]  host_stat,
  output logic        ovf,
  output logic        tmo,
  input  logic        clr_err,
  output logic [7:0]  drop_cnt,
  output logic [1:0]  ym_addr,
  output logic [7:0]  ym_din,
  output logic        ym_cs_n,
  output logic        ym_wr_n,
  input  logic [7:0]  ym_dout
);

  localparam logic [7:0] PW_LAST  = 8'(WR_PULSE - 1);
  localparam logic [7:0] TMO_LAST = 8'(BUSY_TMO - 1);

  wrq_state_e state;
  wrq_state_e nxt;
  wrq_entry_t head;
  wrq_entry_t wentry;
  logic       f_full;
  logic       f_empty;
  logic       pop;
  logic       cap;
  logic       tmo_hit;
  logic       drop;
  logic [7:0] pcnt;
  logic [7:0] poll_cnt;
  logic [7:0] stat_q;

  assign wentry = '{addr: host_addr, din: host_din};
  assign drop   = host_wr & f_full;

  jt12_wrq_fifo #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (host_wr),
    .pop  (pop),
    .wdata(wentry),
    .rdata(head),
    .full (f_full),
    .empty(f_empty),
    .level(host_level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt     = state;
    pop     = 1'b0;
    cap     = 1'b0;
    tmo_hit = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!f_empty) begin
          pop = 1'b1;
          nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        if (pcnt == PW_LAST) nxt = S_RECOV;
      end
      S_RECOV: begin
        // Only data writes make the core busy.
        nxt = ym_addr[0] ? S_POLL : S_IDLE;
      end
      S_POLL: nxt = S_SAMPLE;
      S_SAMPLE: begin
        cap = 1'b1;
        if (!ym_dout[BUSY_BIT]) begin
          nxt = S_IDLE;
        end else if (poll_cnt < TMO_LAST) begin
          nxt = S_POLL;
        end else begin
          tmo_hit = 1'b1;
          nxt     = S_IDLE;
        end
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt     <= '0;
      poll_cnt <= '0;
      ym_addr  <= '0;
      ym_din   <= '0;
      ym_cs_n  <= 1'b1;
      ym_wr_n  <= 1'b1;
      stat_q   <= '0;
      ovf      <= 1'b0;
      tmo      <= 1'b0;
    end else begin
      if (state == S_WRITE && nxt == S_WRITE)
        pcnt <= pcnt + 8'd1;
      else
        pcnt <= '0;
      // poll_cnt counts samples already taken.
      if (state == S_RECOV)
        poll_cnt <= '0;
      else if (state == S_SAMPLE && nxt == S_POLL)
        poll_cnt <= poll_cnt + 8'd1;
      if (pop) begin
        ym_addr <= head.addr;
        ym_din  <= head.din;
      end else if (nxt == S_POLL) begin
        ym_addr <= 2'd0;
      end
      ym_cs_n <= ~(nxt == S_WRITE || nxt == S_POLL);
      ym_wr_n <= (nxt != S_WRITE);
      if (cap) stat_q <= ym_dout;
      if (drop)         ovf <= 1'b1;
      else if (clr_err) ovf <= 1'b0;
      if (tmo_hit)      tmo <= 1'b1;
      else if (clr_err) tmo <= 1'b0;
    end
  end

`ifdef JT12_WRQ_DROPCNT_EN
  logic [7:0] drop_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= '0;
    end else if (drop) begin
      if (clr_err)              drop_q <= 8'd1;
      else if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
    end else if (clr_err) begin
      drop_q <= '0;
    end
  end

  assign drop_cnt = drop_q;
`else
  assign drop_cnt = 8'd0;
`endif

  assign host_full  = f_full;
  assign host_empty = f_empty & (state == S_IDLE);
  // Host sees busy until every queued write has landed.
  assign host_stat  = {stat_q[7] | ~host_empty, stat_q[6:0]};

endmodule

// File: tb/tb_jt12_wrqueue.sv
// Scoreboard bench for jt12_wrqueue with a small jt12 busy model.
// Honors JT12_WRQ_DROPCNT_EN for the expected drop count.
module tb_jt12_wrqueue;
  import jt12_wrqueue_pkg::*;

  localparam int DEPTH    = 16;
  localparam int AW       = 4;
  localparam int WR_PULSE = 2;
  localparam int BUSY_TMO = 16;

  logic        clk;
  logic        rst_n;
  logic        host_wr;
  logic [1:0]  host_addr;
  logic [7:0]  host_din;
  logic        host_full;
  logic        host_empty;
  logic [AW:0] host_level;
  logic [7:0]  host_stat;
  logic        ovf;
  logic        tmo;
  logic        clr_err;
  logic [7:0]  drop_cnt;
  logic [1:0]  ym_addr;
  logic [7:0]  ym_din;
  logic        ym_cs_n;
  logic        ym_wr_n;
  logic [7:0]  ym_dout;

  int checks   = 0;
  int failures = 0;
  logic [9:0] exp_q [$];

  bit stuck;
  int busy_len;
  int busy_cnt;
  bit in_wr;
  int wr_len;
  logic [9:0] wr_ent;
  int polls;

  jt12_wrqueue #(
    .DEPTH   (DEPTH),
    .AW      (AW),
    .WR_PULSE(WR_PULSE),
    .BUSY_TMO(BUSY_TMO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .host_wr   (host_wr),
    .host_addr (host_addr),
    .host_din  (host_din),
    .host_full (host_full),
    .host_empty(host_empty),
    .host_level(host_level),
    .host_stat (host_stat),
    .ovf       (ovf),
    .tmo       (tmo),
    .clr_err   (clr_err),
    .drop_cnt  (drop_cnt),
    .ym_addr   (ym_addr),
    .ym_din    (ym_din),
    .ym_cs_n   (ym_cs_n),
    .ym_wr_n   (ym_wr_n),
    .ym_dout   (ym_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core model: busy for busy_len cycles after a data write.
  assign ym_dout = {(stuck || busy_cnt != 0), 7'h2A};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      busy_cnt <= 0;
    else if (!ym_cs_n && !ym_wr_n && ym_addr[0])
      busy_cnt <= busy_len;
    else if (busy_cnt != 0)
      busy_cnt <= busy_cnt - 1;
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Monitor: pops the scoreboard at the end of each write pulse.
  initial begin
    in_wr = 0;
    polls = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_wr = 0;
      end else if (!ym_cs_n && !ym_wr_n) begin
        if (!in_wr) begin
          in_wr  = 1;
          wr_len = 0;
          wr_ent = {ym_addr, ym_din};
          if (!stuck) chk("busy_gate", busy_cnt, 0);
        end
        wr_len++;
      end else begin
        if (in_wr) begin
          in_wr = 0;
          chk("wr_pulse_len", wr_len, WR_PULSE);
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write actual=%0h required=none",
                     wr_ent);
          end else begin
            chk("wr_entry", wr_ent, exp_q.pop_front());
          end
        end
        if (!ym_cs_n && ym_wr_n) begin
          polls++;
          chk("poll_addr", ym_addr, 0);
        end
      end
    end
  end

  task automatic push(input logic [1:0] a,
                      input logic [7:0] d,
                      input bit ok);
    host_addr = a;
    host_din  = d;
    host_wr   = 1'b1;
    if (ok) exp_q.push_back({a, d});
    @(posedge clk);
    #1;
    host_wr = 1'b0;
  endtask

  task automatic wait_empty(input string nm, input int budget);
    int n;
    n = 0;
    while (!(host_empty && exp_q.size() == 0) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(nm, host_empty, 1);
    chk({nm, "_sb"}, exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int pb;
    bit found;
    logic [7:0] exp_drop;
`ifdef JT12_WRQ_DROPCNT_EN
    exp_drop = 8'd1;
`else
    exp_drop = 8'd0;
`endif
    rst_n     = 1'b0;
    host_wr   = 1'b0;
    host_addr = '0;
    host_din  = '0;
    clr_err   = 1'b0;
    stuck     = 1'b0;
    busy_len  = 4;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs_n", ym_cs_n, 1);
    chk("rst_wr_n", ym_wr_n, 1);
    chk("rst_bus", {ym_addr, ym_din}, 0);
    chk("rst_stat", host_stat, 0);
    chk("rst_flags", {ovf, tmo, host_full}, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_level", host_level, 0);
    chk("rst_empty", host_empty, 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single address write: one pulse, no polling.
    pb = polls;
    push(2'd0, 8'h28, 1);
    chk("t1_level", host_level, 1);
    chk("t1_empty", host_empty, 0);
    @(posedge clk);
    #1;
    chk("t1_latency", {ym_cs_n, ym_wr_n}, 0);
    chk("t1_bus", {ym_addr, ym_din}, {2'd0, 8'h28});
    wait_empty("t1_drain", 50);
    chk("t1_polls", polls - pb, 0);
    chk("t1_stat", host_stat, 0);

    // Address + data write, then a write gated by busy.
    busy_len = 10;
    pb = polls;
    push(2'd0, 8'h28, 1);
    push(2'd1, 8'hF0, 1);
    push(2'd2, 8'h33, 1);
    n = 0;
    while (polls == pb && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("t2_poll_seen", polls != pb, 1);
    chk("t2_stat_busy", host_stat[7], 1);
    wait_empty("t2_drain", 200);
    chk("t2_multi_poll", (polls - pb) >= 2, 1);
    chk("t2_stat", host_stat, 8'h2A);
    chk("t2_tmo", tmo, 0);

    // Stuck busy: fill while the FSM polls, drop one, time out.
    stuck    = 1'b1;
    busy_len = 3;
    push(2'd1, 8'hA5, 1);
    pb = polls;
    n = 0;
    while (polls == pb && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("t3_poll_seen", polls != pb, 1);
    pb = polls - 1;
    for (int i = 0; i < 17; i++)
      push((i % 2) ? 2'd3 : 2'd0, 8'(8'h40 + i), i < 16);
    chk("t3_level", host_level, 16);
    chk("t3_full", host_full, 1);
    chk("t3_ovf", ovf, 1);
    chk("t3_drop", drop_cnt, exp_drop);
    n = 0;
    while (!tmo && n < 80) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("t3_tmo", tmo, 1);
    chk("t3_samples", polls - pb, BUSY_TMO);
    chk("t3_stat", host_stat, 8'hAA);
    stuck   = 1'b0;
    clr_err = 1'b1;
    @(posedge clk);
    #1;
    clr_err = 1'b0;
    chk("t3_clr_flags", {ovf, tmo}, 0);
    chk("t3_clr_drop", drop_cnt, 0);
    wait_empty("t3_drain", 2000);
    chk("t3_no_tmo", tmo, 0);

    // Push coinciding with a pop at level 3.
    busy_len = 6;
    push(2'd1, 8'h11, 1);
    push(2'd0, 8'h22, 1);
    push(2'd2, 8'h33, 1);
    push(2'd0, 8'h44, 1);
    found = 0;
    n = 0;
    while (!found && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (!ym_cs_n && ym_wr_n) begin
        @(posedge clk);
        #1;
        n++;
        if (!ym_dout[7]) found = 1;
      end
    end
    chk("t6_idle_seen", found, 1);
    @(posedge clk);
    #1;
    chk("t6_level_pre", host_level, 3);
    push(2'd0, 8'h55, 1);
    chk("t6_level_post", host_level, 3);
    chk("t6_pop", ym_cs_n, 0);
    chk("t6_stat_forced", host_stat, 8'hAA);
    wait_empty("t6_drain", 300);

    // Reset in the middle of a write.
    for (int i = 0; i < 5; i++)
      push((i % 2) ? 2'd2 : 2'd0, 8'(8'h80 + i), 1);
    n = 0;
    while (!(!ym_cs_n && !ym_wr_n) && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("t5_in_write", {ym_cs_n, ym_wr_n}, 0);
    #1;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("t5_bus", {ym_cs_n, ym_wr_n}, 2'b11);
    chk("t5_level", host_level, 0);
    chk("t5_empty", host_empty, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    push(2'd0, 8'h66, 1);
    wait_empty("t5_recover", 50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
